// File: rtl/msp_pkg.sv
`default_nettype none
// ============================================================================
// Package  : msp_pkg
// Brief    : Loader state encoding and defaults; CSUM exists only when
//            PROG_LOADER_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package msp_pkg;

    localparam int c_TIMEOUT_DEFAULT = 1000;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_COUNT = 3'd1;
    localparam state_t c_ST_HI    = 3'd2;
    localparam state_t c_ST_LO    = 3'd3;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t c_ST_CSUM  = 3'd4;
`endif
    localparam state_t c_ST_DONE  = 3'd5;
    localparam state_t c_ST_ERR   = 3'd6;

    // State entered once the last word has been received
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t c_ST_TAIL  = c_ST_CSUM;
`else
    localparam state_t c_ST_TAIL  = c_ST_DONE;
`endif

    // States in which the loader is consuming bytes
    function automatic logic state_is_active(input state_t s);
        logic v;
        v = 1'b0;
        case (s)
            c_ST_COUNT, c_ST_HI, c_ST_LO: v = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            c_ST_CSUM: v = 1'b1;
`endif
            default: v = 1'b0;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/loader_timer.sv
`default_nettype none
// ============================================================================
// Module   : loader_timer
// Brief    : Inter-byte idle counter; o_expire flags the TIMEOUT-th idle cycle.
// Revision : 1.0 - initial release
// ============================================================================
module loader_timer
    import msp_pkg::*;
#(
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int              c_CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != c_LAST)) begin
            r_count <= r_count + c_CW'(1);
        end
    end

    // Fires on the cycle that would bring the idle count up to TIMEOUT
    assign o_expire = i_enable && !i_clear && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Loads a byte-streamed program (N, then hi/lo word pairs) into
//            program memory, then releases the CPU. Macro
//            PROG_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader
    import msp_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_req,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              RUN,
    output logic              cpu_rst,
    output logic              busy,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [31:0] c_MAX_WORDS = 32'(1) << ADDR_W;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ADDR_W:0] r_n;
    logic [7:0]      r_hi;
    logic            w_accept;
    logic            w_expire;
    logic            w_active;
    logic [31:0]     w_n_val;
    logic            w_n_bad;
    logic [ADDR_W:0] w_words_inc;
    logic            w_last_word;
    logic            w_csum_ok;

    assign w_accept    = rx_valid && rx_ready;
    assign w_active    = state_is_active(r_state);
    // A zero count means a full memory only when the byte cannot express it
    assign w_n_val     = ((ADDR_W == 8) && (rx_data == 8'd0)) ? c_MAX_WORDS
                                                               : {24'd0, rx_data};
    assign w_n_bad     = (ADDR_W < 8) && (w_n_val > c_MAX_WORDS);
    assign w_words_inc = words_loaded + (ADDR_W + 1)'(1);
    assign w_last_word = (w_words_inc == r_n);

    loader_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (load_req || w_accept),
        .i_enable (w_active),
        .o_expire (w_expire)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (rst || load_req) begin
            r_csum <= 8'd0;
        end else if (w_accept && ((r_state == c_ST_HI) || (r_state == c_ST_LO))) begin
            r_csum <= r_csum ^ rx_data;
        end
    end

    assign w_csum_ok = (rx_data == r_csum);
`else
    assign w_csum_ok = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        if (load_req) begin
            w_state_nxt = c_ST_COUNT;
        end else if (w_expire) begin
            w_state_nxt = c_ST_ERR;
        end else if (w_accept) begin
            case (r_state)
                c_ST_COUNT: begin
                    if (w_n_bad) begin
                        w_state_nxt = c_ST_ERR;
                    end else if (w_n_val == 32'd0) begin
                        w_state_nxt = c_ST_TAIL;
                    end else begin
                        w_state_nxt = c_ST_HI;
                    end
                end
                c_ST_HI: w_state_nxt = c_ST_LO;
                c_ST_LO: w_state_nxt = w_last_word ? c_ST_TAIL : c_ST_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
                c_ST_CSUM: w_state_nxt = w_csum_ok ? c_ST_DONE : c_ST_ERR;
`endif
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Status outputs are registered copies of the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_n          <= '0;
            r_hi         <= 8'd0;
            rx_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= 16'd0;
            RUN          <= 1'b0;
            cpu_rst      <= 1'b1;
            busy         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            r_state  <= w_state_nxt;
            rx_ready <= state_is_active(w_state_nxt);
            busy     <= state_is_active(w_state_nxt);
            RUN      <= (w_state_nxt == c_ST_DONE);
            cpu_rst  <= (w_state_nxt != c_ST_DONE);
            error    <= (w_state_nxt == c_ST_ERR);
            mem_we   <= 1'b0;
            if (load_req) begin
                words_loaded <= '0;
                r_n          <= '0;
            end else if (w_accept) begin
                case (r_state)
                    c_ST_COUNT: r_n  <= w_n_val[ADDR_W:0];
                    c_ST_HI:    r_hi <= rx_data;
                    c_ST_LO: begin
                        mem_we       <= 1'b1;
                        mem_addr     <= words_loaded[ADDR_W-1:0];
                        mem_wdata    <= {r_hi, rx_data};
                        words_loaded <= w_words_inc;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Self-checking bench for prog_loader; checksum scenarios compile
//            in with PROG_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int ADDR_W    = 8;
    localparam int TIMEOUT   = 1000;
    localparam int MEM_WORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_req = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              RUN;
    logic              cpu_rst;
    logic              busy;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    int         wr_addr_q[$];
    int         wr_data_q[$];
    int         wr_cyc_q[$];
    logic [7:0] prog_bytes[$];
    int         exp_addr[$];
    int         exp_data[$];
    int         exp_words;

    prog_loader #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_req     (load_req),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .RUN          (RUN),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_data_q.push_back(int'(mem_wdata));
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    // Offers one byte until it is taken; a missing handshake counts as a failure
    task automatic send_byte(input logic [7:0] b, input bit keep, output bit stalled);
        bit rdy;
        bit ok;
        ok       = 1'b0;
        stalled  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 64; i++) begin
            rdy = rx_ready;
            tick(1);
            if (rdy) begin
                ok = 1'b1;
                break;
            end
            stalled = 1'b1;
        end
        if (!keep) rx_valid = 1'b0;
        if (!ok) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_byte: byte %h not accepted within 64 cycles", b);
        end
    endtask

    task automatic send_program(input int max_gap, input bit stream, output int stalls);
        bit st;
        stalls = 0;
        foreach (prog_bytes[i]) begin
            send_byte(prog_bytes[i], stream, st);
            if (st) stalls++;
            if (!stream && max_gap > 0) tick($urandom_range(0, max_gap));
        end
        rx_valid = 1'b0;
    endtask

    // Reference: the byte stream for a program and the memory image it should produce
    task automatic make_program(input int n_field, input logic [7:0] csum_flip);
        int         words;
        logic [7:0] x;
        logic [15:0] w;
        prog_bytes.delete();
        exp_addr.delete();
        exp_data.delete();
        words = (n_field == 0) ? MEM_WORDS : n_field;
        prog_bytes.push_back(8'(n_field));
        x = 8'd0;
        for (int i = 0; i < words; i++) begin
            w = 16'($urandom);
            prog_bytes.push_back(w[15:8]);
            prog_bytes.push_back(w[7:0]);
            x = x ^ w[15:8] ^ w[7:0];
            exp_addr.push_back(i % MEM_WORDS);
            exp_data.push_back(int'(w));
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        prog_bytes.push_back(x ^ csum_flip);
`else
        if (csum_flip != 8'd0) x = 8'd0;
`endif
        exp_words = words;
    endtask

    task automatic wait_settled(input string name);
        int n;
        n = 0;
        while (RUN !== 1'b1 && error !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        tests_run++;
        if (n >= 40) begin
            tests_failed++;
            $display("FAIL %s_settle: no RUN/error after 40 cycles", name);
        end
        tick(2);
    endtask

    task automatic test_reset();
        rst = 1'b1; load_req = 1'b0; rx_valid = 1'b0;
        tick(3);
        tests_run++;
        if ({RUN, cpu_rst, mem_we, busy, error, rx_ready} !== 6'b010000) begin
            tests_failed++;
            $display("FAIL reset_flags: got RUN,cpu_rst,we,busy,err,rdy=%b expected 010000",
                     {RUN, cpu_rst, mem_we, busy, error, rx_ready});
        end
        tests_run++;
        if (mem_addr !== '0 || mem_wdata !== 16'd0 || words_loaded !== '0) begin
            tests_failed++;
            $display("FAIL reset_regs: got addr=%h data=%h wl=%0d expected 0/0/0",
                     mem_addr, mem_wdata, words_loaded);
        end
        load_req = 1'b1;
        tick(1);
        load_req = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || rx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_over_load: got busy=%b rdy=%b expected 0/0", busy, rx_ready);
        end
        rst = 1'b0;
        tick(3);
        tests_run++;
        if (busy !== 1'b0 || rx_ready !== 1'b0 || cpu_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL idle_hold: got busy=%b rdy=%b cpu_rst=%b expected 0/0/1",
                     busy, rx_ready, cpu_rst);
        end
    endtask

    task automatic test_basic();
        int stalls;
        clear_log();
        prog_bytes = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef PROG_LOADER_CHECKSUM_EN
        prog_bytes.push_back(8'h40);
`endif
        exp_addr = '{0, 1};
        exp_data = '{32'h1234, 32'hABCD};
        pulse_load();
        tests_run++;
        if (busy !== 1'b1 || cpu_rst !== 1'b1 || RUN !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_start: got busy=%b cpu_rst=%b RUN=%b expected 1/1/0",
                     busy, cpu_rst, RUN);
        end
        send_program(0, 1'b0, stalls);
        wait_settled("basic");
        tests_run++;
        if (wr_addr_q.size() != 2) begin
            tests_failed++;
            $display("FAIL basic_wr_count: got %0d expected 2", wr_addr_q.size());
        end else begin
            foreach (exp_addr[i]) begin
                tests_run++;
                if (wr_addr_q[i] != exp_addr[i] || wr_data_q[i] != exp_data[i]) begin
                    tests_failed++;
                    $display("FAIL basic_wr[%0d]: got %h@%0d expected %h@%0d",
                             i, wr_data_q[i], wr_addr_q[i], exp_data[i], exp_addr[i]);
                end
            end
        end
        tests_run++;
        if ({RUN, cpu_rst, busy, error} !== 4'b1000 || words_loaded !== 9'd2) begin
            tests_failed++;
            $display("FAIL basic_done: got RUN,cpu_rst,busy,err=%b wl=%0d expected 1000 wl=2",
                     {RUN, cpu_rst, busy, error}, words_loaded);
        end
    endtask

    task automatic test_reload();
        int stalls;
        clear_log();
        load_req = 1'b1;
        tick(1);
        tests_run++;
        if (RUN !== 1'b0 || words_loaded !== '0 || cpu_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL reload_drop: got RUN=%b wl=%0d cpu_rst=%b expected 0/0/1",
                     RUN, words_loaded, cpu_rst);
        end
        // A byte offered alongside load_req must be dropped, not taken as N
        rx_valid = 1'b1;
        rx_data  = 8'h05;
        tick(1);
        load_req = 1'b0;
        rx_valid = 1'b0;
        prog_bytes = '{8'h01, 8'hBE, 8'hEF};
`ifdef PROG_LOADER_CHECKSUM_EN
        prog_bytes.push_back(8'hBE ^ 8'hEF);
`endif
        send_program(0, 1'b0, stalls);
        wait_settled("reload");
        tests_run++;
        if (wr_addr_q.size() != 1 || wr_addr_q[0] != 0 || wr_data_q[0] != 32'hBEEF) begin
            tests_failed++;
            $display("FAIL reload_write: got %0d writes first %h@%0d expected BEEF@0",
                     wr_addr_q.size(), (wr_data_q.size() > 0) ? wr_data_q[0] : -1,
                     (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1);
        end
        tests_run++;
        if (RUN !== 1'b1 || words_loaded !== 9'd1) begin
            tests_failed++;
            $display("FAIL reload_done: got RUN=%b wl=%0d expected 1/1", RUN, words_loaded);
        end
    endtask

    task automatic test_back_to_back();
        int stalls;
        clear_log();
        make_program(4, 8'd0);
        pulse_load();
        send_program(0, 1'b1, stalls);
        wait_settled("b2b");
        tests_run++;
        if (stalls != 0) begin
            tests_failed++;
            $display("FAIL b2b_stall: got %0d stalls expected 0", stalls);
        end
        tests_run++;
        if (wr_addr_q.size() != exp_words) begin
            tests_failed++;
            $display("FAIL b2b_wr_count: got %0d expected %0d", wr_addr_q.size(), exp_words);
        end else begin
            foreach (exp_addr[i]) begin
                tests_run++;
                if (wr_addr_q[i] != exp_addr[i] || wr_data_q[i] != exp_data[i]) begin
                    tests_failed++;
                    $display("FAIL b2b_wr[%0d]: got %h@%0d expected %h@%0d",
                             i, wr_data_q[i], wr_addr_q[i], exp_data[i], exp_addr[i]);
                end
                if (i > 0) begin
                    tests_run++;
                    if (wr_cyc_q[i] - wr_cyc_q[i-1] != 2) begin
                        tests_failed++;
                        $display("FAIL b2b_spacing[%0d]: got %0d cycles expected 2",
                                 i, wr_cyc_q[i] - wr_cyc_q[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int stalls;
        for (int it = 0; it < 6; it++) begin
            clear_log();
            make_program($urandom_range(1, 16), 8'd0);
            pulse_load();
            send_program(3, 1'b0, stalls);
            wait_settled("random");
            tests_run++;
            if (wr_addr_q.size() != exp_words) begin
                tests_failed++;
                $display("FAIL random%0d_wr_count: got %0d expected %0d",
                         it, wr_addr_q.size(), exp_words);
            end else begin
                foreach (exp_addr[i]) begin
                    tests_run++;
                    if (wr_addr_q[i] != exp_addr[i] || wr_data_q[i] != exp_data[i]) begin
                        tests_failed++;
                        $display("FAIL random%0d_wr[%0d]: got %h@%0d expected %h@%0d",
                                 it, i, wr_data_q[i], wr_addr_q[i], exp_data[i], exp_addr[i]);
                    end
                end
            end
            tests_run++;
            if (RUN !== 1'b1 || error !== 1'b0 || int'(words_loaded) != exp_words) begin
                tests_failed++;
                $display("FAIL random%0d_done: got RUN=%b err=%b wl=%0d expected 1/0/%0d",
                         it, RUN, error, words_loaded, exp_words);
            end
        end
    endtask

    task automatic test_full();
        int stalls;
        int bad;
        clear_log();
        make_program(0, 8'd0);
        pulse_load();
        send_program(0, 1'b1, stalls);
        wait_settled("full");
        bad = 0;
        tests_run++;
        if (wr_addr_q.size() != MEM_WORDS) begin
            tests_failed++;
            $display("FAIL full_wr_count: got %0d expected %0d", wr_addr_q.size(), MEM_WORDS);
        end else begin
            foreach (exp_addr[i]) begin
                if (wr_addr_q[i] != exp_addr[i] || wr_data_q[i] != exp_data[i]) bad++;
            end
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("FAIL full_image: got %0d wrong words expected 0", bad);
            end
        end
        tests_run++;
        if (words_loaded !== 9'(MEM_WORDS) || RUN !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_done: got wl=%0d RUN=%b expected %0d/1",
                     words_loaded, RUN, MEM_WORDS);
        end
    endtask

`ifdef PROG_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        int stalls;
        clear_log();
        prog_bytes = '{8'h01, 8'h12, 8'h34, 8'h26};
        pulse_load();
        send_program(0, 1'b0, stalls);
        wait_settled("csum_good");
        tests_run++;
        if (RUN !== 1'b1 || error !== 1'b0 || wr_addr_q.size() != 1) begin
            tests_failed++;
            $display("FAIL csum_good: got RUN=%b err=%b writes=%0d expected 1/0/1",
                     RUN, error, wr_addr_q.size());
        end
        prog_bytes = '{8'h01, 8'h12, 8'h34, 8'h27};
        pulse_load();
        send_program(0, 1'b0, stalls);
        wait_settled("csum_bad");
        tests_run++;
        if (RUN !== 1'b0 || error !== 1'b1 || cpu_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL csum_bad: got RUN=%b err=%b cpu_rst=%b expected 0/1/1",
                     RUN, error, cpu_rst);
        end
        make_program($urandom_range(2, 6), 8'h01 << $urandom_range(0, 7));
        pulse_load();
        send_program(2, 1'b0, stalls);
        wait_settled("csum_rand");
        tests_run++;
        if (error !== 1'b1) begin
            tests_failed++;
            $display("FAIL csum_rand_bad: got err=%b expected 1", error);
        end
    endtask
`endif

    task automatic test_timeout();
        int stalls;
        clear_log();
        prog_bytes = '{8'h03, 8'hAA, 8'h55};
        pulse_load();
        send_program(0, 1'b0, stalls);
        tick(TIMEOUT - 10);
        tests_run++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_early: got err=%b busy=%b expected 0/1", error, busy);
        end
        tick(15);
        tests_run++;
        if ({error, RUN, cpu_rst, busy, rx_ready} !== 5'b10100) begin
            tests_failed++;
            $display("FAIL timeout_err: got err,RUN,cpu_rst,busy,rdy=%b expected 10100",
                     {error, RUN, cpu_rst, busy, rx_ready});
        end
        rx_valid = 1'b1;
        rx_data  = 8'h66;
        tick(6);
        rx_valid = 1'b0;
        tick(2);
        tests_run++;
        if (wr_addr_q.size() != 1 || error !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_no_write: got %0d writes err=%b expected 1/1",
                     wr_addr_q.size(), error);
        end
    endtask

    task automatic test_rst_mid();
        bit st;
        clear_log();
        pulse_load();
        send_byte(8'h02, 1'b0, st);
        send_byte(8'h77, 1'b0, st);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h88;
        tick(1);
        tests_run++;
        if ({busy, rx_ready, RUN, cpu_rst, mem_we} !== 5'b00010 || words_loaded !== '0) begin
            tests_failed++;
            $display("FAIL rst_mid_idle: got busy,rdy,RUN,cpu_rst,we=%b wl=%0d expected 00010 wl=0",
                     {busy, rx_ready, RUN, cpu_rst, mem_we}, words_loaded);
        end
        tick(1);
        rst = 1'b0;
        tick(5);
        rx_valid = 1'b0;
        tick(1);
        tests_run++;
        if (wr_addr_q.size() != 0 || rx_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_no_write: got %0d writes rdy=%b expected 0/0",
                     wr_addr_q.size(), rx_ready);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reload();
        test_back_to_back();
        test_random();
        test_full();
`ifdef PROG_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_timeout();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
